// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter that time-shares one 16-bit ripple-carry adder among NUM_REQ requesters.
// Latency: accept at edge T, CALC in cycle T+1, response valid from cycle T+2 (3 cycles minimum per op).
// Backpressure: RESP holds sum/carry/valid stable until the granted requester's resp_ready_i is high.
//
// Ports: clk/rst_n (async active-low); req_valid_i/req_ready_o/req_a_i/req_b_i request side
// (16-bit operand lanes packed per requester); resp_valid_o/resp_ready_i/resp_sum_o/resp_carry_o
// response side; busy_o high outside IDLE; op_count_o counts completed responses (wraps).

module bsg_adder_ripple_carry #(
    parameter int width_p = 16
) (
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic [width_p-1:0] s_o,
    output logic               c_o
);
    logic [width_p:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < width_p; i++) begin : g_bit
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (a_i[i] & c[i]) | (b_i[i] & c[i]);
    end

    assign c_o = c[width_p];
endmodule

module shared_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*16-1:0] req_a_i,
    input  logic [NUM_REQ*16-1:0] req_b_i,
    output logic [NUM_REQ-1:0]    resp_valid_o,
    input  logic [NUM_REQ-1:0]    resp_ready_i,
    output logic [15:0]           resp_sum_o,
    output logic                  resp_carry_o,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      op_count_o
);
    localparam int W     = 16;
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_r;
    logic [W-1:0]       op_a_r;
    logic [W-1:0]       op_b_r;
    logic [W-1:0]       sum_r;
    logic               carry_r;
    logic [CNT_W-1:0]   op_cnt_r;
    logic [NUM_REQ-1:0] resp_valid_r;
    logic               busy_r;

    logic [W-1:0]       add_sum;
    logic               add_carry;

    logic               gnt_any;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W:0]     cand;

    bsg_adder_ripple_carry #(.width_p(W)) u_adder (
        .a_i (op_a_r),
        .b_i (op_b_r),
        .s_o (add_sum),
        .c_o (add_carry)
    );

    // Search upward from rr_ptr, wrapping; the first valid requester wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!gnt_any && req_valid_i[cand[PTR_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[PTR_W-1:0];
            end
        end
    end

    // Gated by rst_n so the combinational ready is also silent while reset is held.
    assign req_ready_o = (rst_n && state == IDLE && gnt_any) ?
                         (NUM_REQ'(1) << gnt_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            gnt_r        <= '0;
            op_a_r       <= '0;
            op_b_r       <= '0;
            sum_r        <= '0;
            carry_r      <= 1'b0;
            op_cnt_r     <= '0;
            resp_valid_r <= '0;
            busy_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        op_a_r <= req_a_i[gnt_idx*W +: W];
                        op_b_r <= req_b_i[gnt_idx*W +: W];
                        gnt_r  <= gnt_idx;
                        busy_r <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    sum_r        <= add_sum;
                    carry_r      <= add_carry;
                    resp_valid_r <= NUM_REQ'(1) << gnt_r;
                    state        <= RESP;
                end
                RESP: begin
                    if (resp_ready_i[gnt_r]) begin
                        op_cnt_r     <= op_cnt_r + 1'b1;
                        rr_ptr       <= (gnt_r == PTR_W'(NUM_REQ-1)) ? '0 : gnt_r + 1'b1;
                        resp_valid_r <= '0;
                        busy_r       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    resp_valid_r <= '0;
                    busy_r       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid_o = resp_valid_r;
    assign resp_sum_o   = sum_r;
    assign resp_carry_o = carry_r;
    assign busy_o       = busy_r;
    assign op_count_o   = op_cnt_r;
endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed bench for shared_adder_arbiter (NUM_REQ=4, CNT_W=8).
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
// Each scenario task checks its own expectations inline.
module tb_shared_adder_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_ready;
    logic [15:0] resp_sum;
    logic        resp_carry;
    logic        busy;
    logic [7:0]  op_count;

    int total = 0;
    int bad   = 0;

    logic [15:0] ca [4] = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'hFFFF};
    logic [15:0] cb [4] = '{16'h0001, 16'h8000, 16'h0001, 16'hFFFF};
    logic [15:0] cs [4] = '{16'h0000, 16'h0000, 16'h8000, 16'hFFFE};
    logic        cc [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    logic [15:0] ra [4] = '{16'h1111, 16'h2222, 16'h3333, 16'hF000};
    logic [15:0] rb [4] = '{16'h0001, 16'h0010, 16'h0100, 16'h1001};
    logic [15:0] rs [4] = '{16'h1112, 16'h2232, 16'h3433, 16'h0001};
    logic        rc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    shared_adder_arbiter #(.NUM_REQ(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_sum_o   (resp_sum),
        .resp_carry_o (resp_carry),
        .busy_o       (busy),
        .op_count_o   (op_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset;
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = 4'hF;
        req_a      = '0;
        req_b      = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        req_valid  = 4'hF;
        resp_ready = 4'hF;
        req_a      = '0;
        req_b      = '0;
        #1;
        total++;
        if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_req_ready got=%h exp=0", req_ready); end
        tick();
        total++;
        if ({resp_valid, resp_sum, resp_carry, busy, op_count} !== 38'h0) begin
            bad++;
            $display("FAIL reset_outputs got rv=%h sum=%h c=%b busy=%b cnt=%h exp all 0",
                     resp_valid, resp_sum, resp_carry, busy, op_count);
        end
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single;
        req_a[15:0] = 16'h0001;
        req_b[15:0] = 16'h0002;
        req_valid   = 4'b0001;
        resp_ready  = 4'hF;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        total++;
        if (busy !== 1'b1 || resp_valid !== 4'b0 || req_ready !== 4'b0) begin
            bad++;
            $display("FAIL single_calc got busy=%b rv=%b rr=%b exp 1/0000/0000", busy, resp_valid, req_ready);
        end
        tick();
        total++;
        if (resp_valid !== 4'b0001 || resp_sum !== 16'h0003 || resp_carry !== 1'b0) begin
            bad++;
            $display("FAIL single_resp got rv=%b sum=%h c=%b exp 0001/0003/0", resp_valid, resp_sum, resp_carry);
        end
        tick();
        total++;
        if (op_count !== 8'd1 || busy !== 1'b0 || resp_valid !== 4'b0) begin
            bad++;
            $display("FAIL single_done got cnt=%0d busy=%b rv=%b exp 1/0/0000", op_count, busy, resp_valid);
        end
    endtask

    task automatic test_carry;
        for (int k = 0; k < 4; k++) begin
            req_a[15:0] = ca[k];
            req_b[15:0] = cb[k];
            req_valid   = 4'b0001;
            #1;
            tick();
            req_valid = '0;
            tick();
            total++;
            if (resp_valid !== 4'b0001 || resp_sum !== cs[k] || resp_carry !== cc[k]) begin
                bad++;
                $display("FAIL carry_%0d got rv=%b sum=%h c=%b exp 0001/%h/%b",
                         k, resp_valid, resp_sum, resp_carry, cs[k], cc[k]);
            end
            tick();
        end
    endtask

    task automatic test_round_robin;
        int g;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[16*i +: 16] = ra[i];
            req_b[16*i +: 16] = rb[i];
        end
        req_valid  = 4'hF;
        resp_ready = 4'hF;
        for (int k = 0; k < 6; k++) begin
            g = k % 4;
            #1;
            total++;
            if (req_ready !== 4'(1 << g) || busy !== 1'b0) begin
                bad++;
                $display("FAIL rr_grant_%0d got rr=%b busy=%b exp %b/0", k, req_ready, busy, 4'(1 << g));
            end
            tick();
            tick();
            total++;
            if (resp_valid !== 4'(1 << g) || resp_sum !== rs[g] || resp_carry !== rc[g]) begin
                bad++;
                $display("FAIL rr_resp_%0d got rv=%b sum=%h c=%b exp %b/%h/%b",
                         k, resp_valid, resp_sum, resp_carry, 4'(1 << g), rs[g], rc[g]);
            end
            tick();
        end
        req_valid = '0;
        #1;
        total++;
        if (op_count !== 8'd6) begin bad++; $display("FAIL rr_count got=%0d exp=6", op_count); end
    endtask

    task automatic test_backpressure;
        apply_reset();
        req_a[31:16] = 16'h1234;
        req_b[31:16] = 16'h4321;
        req_valid    = 4'b0010;
        resp_ready   = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant got=%b exp=0010", req_ready); end
        tick();
        req_valid = 4'b1101;
        tick();
        for (int k = 0; k < 5; k++) begin
            total++;
            if (resp_valid !== 4'b0010 || resp_sum !== 16'h5555 || req_ready !== 4'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold_%0d got rv=%b sum=%h rr=%b busy=%b exp 0010/5555/0000/1",
                         k, resp_valid, resp_sum, req_ready, busy);
            end
            tick();
        end
        resp_ready = 4'b0010;
        tick();
        total++;
        if (op_count !== 8'd1 || req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL bp_release got cnt=%0d rr=%b exp 1/0100", op_count, req_ready);
        end
        req_valid = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        int seen0;
        apply_reset();
        // First op on requester 2 moves rr_ptr to 3.
        req_a[47:32] = 16'h0005;
        req_b[47:32] = 16'h0006;
        req_valid    = 4'b0100;
        resp_ready   = 4'hF;
        tick();
        req_valid = '0;
        tick();
        tick();
        req_a[15:0] = 16'hAAAA;
        req_b[15:0] = 16'h1111;
        req_valid   = 4'b0001;
        tick();
        req_valid = 4'b1100;
        #1;
        total++;
        if (busy !== 1'b1 || op_count !== 8'd1) begin
            bad++;
            $display("FAIL mid_precond got busy=%b cnt=%0d exp 1/1", busy, op_count);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, resp_valid, resp_sum, resp_carry, busy, op_count} !== 42'h0) begin
            bad++;
            $display("FAIL mid_reset_outputs got rr=%b rv=%b sum=%h c=%b busy=%b cnt=%h exp all 0",
                     req_ready, resp_valid, resp_sum, resp_carry, busy, op_count);
        end
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL mid_regrant got=%b exp=0100", req_ready); end
        seen0 = 0;
        tick();
        req_valid = '0;
        if (resp_valid[0] !== 1'b0) seen0++;
        tick();
        if (resp_valid[0] !== 1'b0) seen0++;
        total++;
        if (resp_valid !== 4'b0100 || resp_sum !== 16'h000B || resp_carry !== 1'b0) begin
            bad++;
            $display("FAIL mid_resp got rv=%b sum=%h c=%b exp 0100/000b/0", resp_valid, resp_sum, resp_carry);
        end
        tick();
        if (resp_valid[0] !== 1'b0) seen0++;
        tick();
        if (resp_valid[0] !== 1'b0) seen0++;
        total++;
        if (seen0 !== 0 || op_count !== 8'd1) begin
            bad++;
            $display("FAIL mid_no_stale got req0_resp_cycles=%0d cnt=%0d exp 0/1", seen0, op_count);
        end
    endtask

    task automatic test_counter_wrap;
        apply_reset();
        req_a[15:0] = 16'h0001;
        req_b[15:0] = 16'h0001;
        req_valid   = 4'b0001;
        resp_ready  = 4'hF;
        repeat (3 * 255) tick();
        total++;
        if (op_count !== 8'hFF) begin bad++; $display("FAIL wrap_ff got=%h exp=ff", op_count); end
        repeat (3) tick();
        total++;
        if (op_count !== 8'h00) begin bad++; $display("FAIL wrap_00 got=%h exp=00", op_count); end
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
